// File: rtl/atctlc2axi500_burst_arb.sv
// Burst-locking N:1 fixed-priority arbiter with a registered output stage.
// Lowest index wins in IDLE; the winner keeps the grant until its last beat.
module atctlc2axi500_burst_arb #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int SW = 2
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [SW-1:0]   lock_idx;
    logic [SW-1:0]   sel;
    logic            have_sel;
    logic            slot_free;
    logic            grant;
    logic            accept;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;

    assign slot_free = ~out_valid | out_ready;

    // Priority encoder: scan high to low so the lowest valid index wins.
    always_comb begin
        sel      = '0;
        have_sel = 1'b0;
        if (state == LOCK) begin
            sel      = lock_idx;
            have_sel = 1'b1;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    sel      = SW'(i);
                    have_sel = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == sel) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DW +: DW];
            end
        end
    end

    assign grant = ~areset & have_sel & slot_free;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = grant & (SW'(i) == sel);
        end
    end

    assign accept = grant & sel_valid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            lock_idx  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_last  <= sel_last;
                out_data  <= sel_data;
                out_src   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept && !sel_last) begin
                        state    <= LOCK;
                        lock_idx <= sel;
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OVL_ASSERT_ON
    a_ready_onehot0: assert property (
        @(posedge aclk) disable iff (areset) $onehot0(in_ready));

    for (genvar g = 0; g < N; g++) begin : g_hold
        a_hold: assert property (
            @(posedge aclk) disable iff (areset)
            (in_valid[g] && !in_ready[g]) |=>
            (in_valid[g] && $stable(in_last[g]) &&
             $stable(in_data[g*DW +: DW])));
    end
`endif

endmodule

// File: tb/tb_atctlc2axi500_burst_arb.sv
// Directed self-checking bench for atctlc2axi500_burst_arb.
// Inputs change 1ns after each rising edge; checks happen 1ns later.
module tb_atctlc2axi500_burst_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    atctlc2axi500_burst_arb #(.N(N), .DW(DW), .SW(SW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int i, input logic v, input logic l,
                       input logic [DW-1:0] d);
        in_valid[i]         = v;
        in_last[i]          = l;
        in_data[i*DW +: DW] = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic l,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_src"}, 32'(out_src), 32'(s));
    endtask

    initial begin
        areset    = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        tick();
        req(0, 1'b1, 1'b1, 32'h0000_0011);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("rst_out", 1'b0, 1'b0, 32'h0, 2'd0);
        req(0, 1'b0, 1'b0, 32'h0);
        areset = 1'b0;

        // Idle for 10 cycles, then a single beat with 1-cycle latency
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("idle_in_ready", 32'(in_ready), 32'h0);
            chk("idle_out_valid", 32'(out_valid), 32'h0);
            tick();
        end
        req(0, 1'b1, 1'b1, 32'h0000_0011);
        #1;
        chk("idle_first_grant", 32'(in_ready), 32'h1);
        tick();
        req(0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("idle_first_out", 1'b1, 1'b1, 32'h0000_0011, 2'd0);
        tick();

        // Priority: req2 and req3 single beats
        req(2, 1'b1, 1'b1, 32'h0000_0022);
        req(3, 1'b1, 1'b1, 32'h0000_0033);
        #1;
        chk("pri_ready_a", 32'(in_ready), 32'h4);
        tick();
        req(2, 1'b0, 1'b0, 32'h0);
        #1;
        chk("pri_ready_b", 32'(in_ready), 32'h8);
        chk_out("pri_out_a", 1'b1, 1'b1, 32'h0000_0022, 2'd2);
        tick();
        req(3, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("pri_out_b", 1'b1, 1'b1, 32'h0000_0033, 2'd3);
        chk("pri_ready_c", 32'(in_ready), 32'h0);
        tick();
        #1;
        chk("pri_drain", 32'(out_valid), 32'h0);

        // Burst lock: req2 three beats, req0 arrives after beat 1
        req(2, 1'b1, 1'b0, 32'h0000_0201);
        #1;
        chk("lock_ready_b1", 32'(in_ready), 32'h4);
        tick();
        req(0, 1'b1, 1'b1, 32'h0000_000A);
        req(2, 1'b1, 1'b0, 32'h0000_0202);
        #1;
        chk("lock_ready_b2", 32'(in_ready), 32'h4);
        chk_out("lock_out_b1", 1'b1, 1'b0, 32'h0000_0201, 2'd2);
        tick();
        req(2, 1'b1, 1'b1, 32'h0000_0203);
        #1;
        chk("lock_ready_b3", 32'(in_ready), 32'h4);
        chk_out("lock_out_b2", 1'b1, 1'b0, 32'h0000_0202, 2'd2);
        tick();
        req(2, 1'b0, 1'b0, 32'h0);
        #1;
        chk("lock_release", 32'(in_ready), 32'h1);
        chk_out("lock_out_b3", 1'b1, 1'b1, 32'h0000_0203, 2'd2);
        tick();
        req(0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("lock_out_next", 1'b1, 1'b1, 32'h0000_000A, 2'd0);
        tick();

        // Backpressure: hold 0xA5A5A5A5 for 5 cycles
        req(1, 1'b1, 1'b1, 32'hA5A5_A5A5);
        #1;
        chk("bp_ready_first", 32'(in_ready), 32'h2);
        tick();
        out_ready = 1'b0;
        req(1, 1'b1, 1'b1, 32'h5A5A_5A5A);
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_hold_data", out_data, 32'hA5A5_A5A5);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_ready", 32'(in_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        req(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("bp_next", 1'b1, 1'b1, 32'h5A5A_5A5A, 2'd1);
        tick();

        // Locked bubble: req1 stalls 3 cycles while req3 waits
        req(1, 1'b1, 1'b0, 32'h0000_0101);
        #1;
        chk("bub_ready_b1", 32'(in_ready), 32'h2);
        tick();
        req(1, 1'b0, 1'b0, 32'h0);
        req(3, 1'b1, 1'b1, 32'h0000_0301);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bub_ready", 32'(in_ready), 32'h2);
            chk("bub_out_valid", 32'(out_valid), (j == 0) ? 32'h1 : 32'h0);
            tick();
        end
        req(1, 1'b1, 1'b1, 32'h0000_0102);
        #1;
        chk("bub_resume_ready", 32'(in_ready), 32'h2);
        chk("bub_resume_valid", 32'(out_valid), 32'h0);
        tick();
        req(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("bub_out_b2", 1'b1, 1'b1, 32'h0000_0102, 2'd1);
        chk("bub_req3_grant", 32'(in_ready), 32'h8);
        tick();
        req(3, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("bub_out_req3", 1'b1, 1'b1, 32'h0000_0301, 2'd3);
        tick();

        // Reset during beat 2 of a req1 burst
        req(1, 1'b1, 1'b0, 32'h0000_0111);
        #1;
        chk("rmid_ready_b1", 32'(in_ready), 32'h2);
        tick();
        req(1, 1'b1, 1'b0, 32'h0000_0112);
        req(0, 1'b1, 1'b1, 32'h0000_000B);
        areset = 1'b1;
        #1;
        chk("rmid_ready_rst", 32'(in_ready), 32'h0);
        tick();
        areset = 1'b0;
        #1;
        chk_out("rmid_out_clr", 1'b0, 1'b0, 32'h0, 2'd0);
        chk("rmid_req0_grant", 32'(in_ready), 32'h1);
        tick();
        req(0, 1'b0, 1'b0, 32'h0);
        req(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk_out("rmid_out_req0", 1'b1, 1'b1, 32'h0000_000B, 2'd0);
        tick();
        #1;
        chk("final_idle", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
